powerup_rect_ctrl: RTL
======================

Name: powerup_rect_ctrl

Overview:
- Drives the powerup bitmap reader. Produces per-pixel offsetX/offsetY and InsideRectangle for a 32x32 powerup sprite.
- Owns the powerup lifecycle: spawn at a requested position, visible lifetime, blinking pre-expiry warning, collection on collision, and expiry.
- Sits between the VGA pixel scanner and the bitmap reader, alongside the collision and game-control logic.

Parameters:
- OBJECT_WIDTH, 32, sprite width in pixels
- OBJECT_HEIGHT, 32, sprite height in pixels
- SCREEN_W, 640, visible screen width
- SCREEN_H, 480, visible screen height
- LIFETIME_FRAMES, 600, total frames from spawn to expiry
- BLINK_FRAMES, 120, final frames of lifetime spent blinking (must be < LIFETIME_FRAMES)
- BLINK_PERIOD, 8, frames per blink half-phase

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- pixelX  in  11  current scan X
- pixelY  in  11  current scan Y
- spawn  in  1  one-cycle spawn request
- spawnX  in  11  requested top-left X (sampled with spawn)
- spawnY  in  11  requested top-left Y (sampled with spawn)
- collision  in  1  player-powerup collision, level
- offsetX  out  11  pixelX - topLeftX when inside, else 0
- offsetY  out  11  pixelY - topLeftY when inside, else 0
- InsideRectangle  out  1  current pixel is within the visible sprite
- topLeftX  out  11  latched sprite X
- topLeftY  out  11  latched sprite Y
- active  out  1  FSM not in HIDDEN
- collected  out  1  one-cycle pulse on collection
- expired  out  1  one-cycle pulse on lifetime end

Behaviour:
- Reset (async, resetN low), takes effect immediately:
  - State HIDDEN.
  - All outputs 0: offsets, InsideRectangle, topLeft, active, collected, expired.
  - frameCnt and blinkCnt 0; blinkOn 1.
- States: HIDDEN, SHOWN, BLINK.
- HIDDEN:
  - On spawn=1, latch topLeftX=min(spawnX, SCREEN_W-OBJECT_WIDTH) and topLeftY=min(spawnY, SCREEN_H-OBJECT_HEIGHT).
  - Clear frameCnt, set blinkOn=1, go to SHOWN on the next edge.
  - collision is ignored in HIDDEN.
- SHOWN:
  - frameCnt increments on each startOfFrame.
  - When the incremented value equals LIFETIME_FRAMES-BLINK_FRAMES, go to BLINK, clear blinkCnt, keep blinkOn=1.
- BLINK:
  - frameCnt keeps counting on startOfFrame.
  - blinkCnt counts frames; when it reaches BLINK_PERIOD-1, it wraps to 0 and blinkOn toggles.
  - When frameCnt reaches LIFETIME_FRAMES, pulse expired for one cycle and go to HIDDEN.
- Collection: collision=1 in SHOWN or BLINK (either blink phase) pulses collected for one cycle and goes to HIDDEN.
- spawn is ignored outside HIDDEN.
- Priority on a single edge:
  - collision beats startOfFrame and lifetime expiry (no expired pulse on that edge).
  - In HIDDEN, spawn beats collision.
- Rectangle test (combinational hit):
  - hit = (state != HIDDEN) && blinkOn && pixelX >= topLeftX && pixelX < topLeftX+OBJECT_WIDTH && pixelY >= topLeftY && pixelY < topLeftY+OBJECT_HEIGHT.
  - Compare using 12-bit sums so there is no overflow.
- Output registration:
  - InsideRectangle, offsetX and offsetY are registered: 1-cycle latency from pixelX/pixelY. Downstream pixel alignment accounts for this.
  - When hit=0, offsets register 0.
  - Offsets are always < OBJECT_WIDTH / OBJECT_HEIGHT.
- active is registered and equals (next state != HIDDEN), i.e. it rises on the edge that leaves HIDDEN.
- Counters:
  - frameCnt width $clog2(LIFETIME_FRAMES+1); never exceeds LIFETIME_FRAMES.
  - blinkCnt width $clog2(BLINK_PERIOD).
- Reset mid-lifetime: immediate return to HIDDEN with no collected/expired pulse.

Test Plan:
- Reset then spawn with spawnX=100, spawnY=50:
  - Next cycle active=1, topLeft=(100,50).
  - Scan pixel (100,50): one cycle later InsideRectangle=1, offsets=(0,0).
  - Pixel (131,81): offsets=(31,31).
  - Pixel (132,81): InsideRectangle=0, offsets=(0,0).
- Spawn with spawnX=630, spawnY=470 -> topLeft clamped to (608,448).
- Spawn, then 480 startOfFrame pulses -> state BLINK.
  - InsideRectangle low over the sprite during frames 488-495, 504-511, and so on.
  - After frame 600, expired pulses once; active=0; no further InsideRectangle.
- collision at frame 10 -> collected pulses for exactly 1 cycle; active=0. A second spawn while SHOWN is ignored (topLeft unchanged).
- collision and startOfFrame on the same edge that would reach frame 600 -> collected=1, expired=0.
- Assert resetN low at frame 300 -> all outputs 0 asynchronously. After release, collision has no effect; a new spawn restarts the lifetime at frameCnt=0.

Source files
------------

// File: rtl/powerup_rect_ctrl.sv
// Powerup sprite controller: spawn/lifetime/blink/collect FSM plus the registered
// rectangle hit test and pixel offsets that feed the 32x32 bitmap reader.
module powerup_rect_ctrl #(
  parameter int OBJECT_WIDTH    = 32,
  parameter int OBJECT_HEIGHT   = 32,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int LIFETIME_FRAMES = 600,
  parameter int BLINK_FRAMES    = 120,
  parameter int BLINK_PERIOD    = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        spawn,
  input  logic [10:0] spawnX,
  input  logic [10:0] spawnY,
  input  logic        collision,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        active,
  output logic        collected,
  output logic        expired
);

  localparam int FW = $clog2(LIFETIME_FRAMES + 1);
  localparam int BW = $clog2(BLINK_PERIOD);

  localparam logic [1:0] S_HIDDEN = 2'd0;
  localparam logic [1:0] S_SHOWN  = 2'd1;
  localparam logic [1:0] S_BLINK  = 2'd2;

  localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
  localparam logic [FW-1:0] SHOWN_END  = FW'(LIFETIME_FRAMES - BLINK_FRAMES);
  localparam logic [FW-1:0] LIFE_END   = FW'(LIFETIME_FRAMES);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
  localparam logic [10:0]   MAX_X      = 11'(SCREEN_W - OBJECT_WIDTH);
  localparam logic [10:0]   MAX_Y      = 11'(SCREEN_H - OBJECT_HEIGHT);
  localparam logic [11:0]   OBJ_W12    = 12'(OBJECT_WIDTH);
  localparam logic [11:0]   OBJ_H12    = 12'(OBJECT_HEIGHT);

  // Keeps the whole sprite on screen.
  function automatic logic [10:0] clamp_pos(input logic [10:0] v, input logic [10:0] lim);
    logic [10:0] r;
    if (v > lim) begin
      r = lim;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d, frame_inc_s;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [10:0]   top_left_x_q, top_left_x_d;
  logic [10:0]   top_left_y_q, top_left_y_d;
  logic          collected_d, expired_d;
  logic          collected_q, expired_q, active_q;
  logic          inside_q;
  logic [10:0]   off_x_q, off_y_q;
  logic          hit_s;
  logic [10:0]   off_x_s, off_y_s;

  assign frame_inc_s = frame_cnt_q + FRAME_ONE;

  // Lifecycle next-state: collision outranks frame ticks and expiry.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    top_left_x_d = top_left_x_q;
    top_left_y_d = top_left_y_q;
    collected_d  = 1'b0;
    expired_d    = 1'b0;
    case (state_q)
      S_HIDDEN: begin
        if (spawn) begin
          top_left_x_d = clamp_pos(spawnX, MAX_X);
          top_left_y_d = clamp_pos(spawnY, MAX_Y);
          frame_cnt_d  = '0;
          blink_cnt_d  = '0;
          blink_on_d   = 1'b1;
          state_d      = S_SHOWN;
        end else begin
          state_d = S_HIDDEN;
        end
      end
      S_SHOWN: begin
        if (collision) begin
          collected_d = 1'b1;
          blink_on_d  = 1'b1;
          state_d     = S_HIDDEN;
        end else if (startOfFrame) begin
          frame_cnt_d = frame_inc_s;
          if (frame_inc_s == SHOWN_END) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
            state_d     = S_BLINK;
          end else begin
            state_d = S_SHOWN;
          end
        end else begin
          state_d = S_SHOWN;
        end
      end
      S_BLINK: begin
        if (collision) begin
          collected_d = 1'b1;
          blink_on_d  = 1'b1;
          state_d     = S_HIDDEN;
        end else if (startOfFrame) begin
          frame_cnt_d = frame_inc_s;
          if (frame_inc_s == LIFE_END) begin
            expired_d  = 1'b1;
            blink_on_d = 1'b1;
            state_d    = S_HIDDEN;
          end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
            state_d     = S_BLINK;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_ONE;
            state_d     = S_BLINK;
          end
        end else begin
          state_d = S_BLINK;
        end
      end
      default: begin
        state_d    = S_HIDDEN;
        blink_on_d = 1'b1;
      end
    endcase
  end

  // Rectangle hit with 12-bit bounds so right/bottom edges cannot wrap.
  always_comb begin
    hit_s   = 1'b0;
    off_x_s = 11'd0;
    off_y_s = 11'd0;
    if ((state_q != S_HIDDEN) && blink_on_q &&
        ({1'b0, pixelX} >= {1'b0, top_left_x_q}) &&
        ({1'b0, pixelX} <  ({1'b0, top_left_x_q} + OBJ_W12)) &&
        ({1'b0, pixelY} >= {1'b0, top_left_y_q}) &&
        ({1'b0, pixelY} <  ({1'b0, top_left_y_q} + OBJ_H12))) begin
      hit_s   = 1'b1;
      off_x_s = pixelX - top_left_x_q;
      off_y_s = pixelY - top_left_y_q;
    end else begin
      hit_s   = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_HIDDEN;
      frame_cnt_q  <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      top_left_x_q <= 11'd0;
      top_left_y_q <= 11'd0;
      collected_q  <= 1'b0;
      expired_q    <= 1'b0;
      active_q     <= 1'b0;
      inside_q     <= 1'b0;
      off_x_q      <= 11'd0;
      off_y_q      <= 11'd0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      top_left_x_q <= top_left_x_d;
      top_left_y_q <= top_left_y_d;
      collected_q  <= collected_d;
      expired_q    <= expired_d;
      active_q     <= (state_d != S_HIDDEN);
      inside_q     <= hit_s;
      off_x_q      <= off_x_s;
      off_y_q      <= off_y_s;
    end
  end

  assign offsetX         = off_x_q;
  assign offsetY         = off_y_q;
  assign InsideRectangle = inside_q;
  assign topLeftX        = top_left_x_q;
  assign topLeftY        = top_left_y_q;
  assign active          = active_q;
  assign collected       = collected_q;
  assign expired         = expired_q;

endmodule
